// File: rtl/lfsr_pattern_gen_if.sv
// Pattern-generator control/stream bundle: run control and seed loading from the
// test controller, plus the pattern stream handshake toward the DUT/compactor.
interface lfsr_pattern_gen_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic             start;
  logic             abort;
  logic             seed_load;
  logic [WIDTH-1:0] seed_in;
  logic [CNT_W-1:0] pattern_count;
  logic             pattern_ready;
  logic             pattern_valid;
  logic [WIDTH-1:0] pattern_out;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] patterns_sent;

  modport master (
    output start, abort, seed_load, seed_in, pattern_count, pattern_ready,
    input  pattern_valid, pattern_out, busy, done, patterns_sent
  );

  modport slave (
    input  start, abort, seed_load, seed_in, pattern_count, pattern_ready,
    output pattern_valid, pattern_out, busy, done, patterns_sent
  );
endinterface

// File: rtl/lfsr_pattern_gen.sv
// Galois-LFSR test pattern generator: issues a counted run of patterns over a
// valid/ready stream, stepping the LFSR only when a pattern is accepted.
module lfsr_pattern_gen #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] POLY     = WIDTH'(32'h8020_0003),
  parameter logic [WIDTH-1:0] DEF_SEED = WIDTH'(32'hACE1_ACE1),
  parameter int               CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  lfsr_pattern_gen_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_lfsr;
  logic [WIDTH-1:0] w_lfsr_next;
  logic [CNT_W-1:0] r_sent;
  logic [CNT_W-1:0] w_sent_next;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_next;
  logic [CNT_W-1:0] w_sent_inc;
  logic [WIDTH-1:0] w_seed_sel;
  logic             w_hs;

  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
    lfsr_step = {s[WIDTH-2:0], 1'b0} ^ (s[WIDTH-1] ? POLY : '0);
  endfunction

  // An all-zero state would lock the LFSR, so a zero seed falls back to DEF_SEED.
  assign w_seed_sel = (bus.seed_in == '0) ? DEF_SEED : bus.seed_in;
  assign w_hs       = (r_state == S_RUN) && bus.pattern_ready;
  assign w_sent_inc = r_sent + CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_lfsr  <= DEF_SEED;
      r_sent  <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_next_state;
      r_lfsr  <= w_lfsr_next;
      r_sent  <= w_sent_next;
      r_count <= w_count_next;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_lfsr_next  = r_lfsr;
    w_sent_next  = r_sent;
    w_count_next = r_count;
    case (r_state)
      S_IDLE: begin
        if (bus.seed_load) w_lfsr_next = w_seed_sel;
        if (bus.start) begin
          w_sent_next = '0;
          if (bus.pattern_count != '0) begin
            w_count_next = bus.pattern_count;
            w_next_state = S_RUN;
          end else begin
            w_next_state = S_DONE;
          end
        end
      end
      S_RUN: begin
        if (w_hs) begin
          w_lfsr_next = lfsr_step(r_lfsr);
          w_sent_next = w_sent_inc;
        end
        // Abort wins over a simultaneous final handshake, which still counts.
        if (bus.abort) w_next_state = S_IDLE;
        else if (w_hs && (w_sent_inc == r_count)) w_next_state = S_DONE;
      end
      S_DONE: begin
        if (bus.seed_load) w_lfsr_next = w_seed_sel;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  assign bus.pattern_valid = (r_state == S_RUN);
  assign bus.busy          = (r_state == S_RUN);
  assign bus.done          = (r_state == S_DONE);
  assign bus.pattern_out   = r_lfsr;
  assign bus.patterns_sent = r_sent;

endmodule

// File: tb/tb_lfsr_pattern_gen.sv
// Directed bench for lfsr_pattern_gen: vector table plus hand-written stall,
// abort and reset sequences.
module tb_lfsr_pattern_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  lfsr_pattern_gen_if #(.WIDTH(32), .CNT_W(16)) bus ();

  lfsr_pattern_gen dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic        abort;
    logic        seed_load;
    logic [31:0] seed_in;
    logic [15:0] count;
    logic        ready;
    logic        e_valid;
    logic [31:0] e_pat;
    logic        e_busy;
    logic        e_done;
    logic [15:0] e_sent;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(input logic st, input logic ab, input logic sl,
                              input logic [31:0] si, input logic [15:0] cnt,
                              input logic rdy, input logic ev, input logic [31:0] ep,
                              input logic eb, input logic ed, input logic [15:0] es);
    vec_t v;
    v.start = st; v.abort = ab; v.seed_load = sl; v.seed_in = si; v.count = cnt;
    v.ready = rdy; v.e_valid = ev; v.e_pat = ep; v.e_busy = eb; v.e_done = ed;
    v.e_sent = es;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic ev, input logic [31:0] ep,
                          input logic eb, input logic ed, input logic [15:0] es);
    chk({tag, ".valid"}, 64'(bus.pattern_valid), 64'(ev));
    chk({tag, ".pattern"}, 64'(bus.pattern_out), 64'(ep));
    chk({tag, ".busy"}, 64'(bus.busy), 64'(eb));
    chk({tag, ".done"}, 64'(bus.done), 64'(ed));
    chk({tag, ".sent"}, 64'(bus.patterns_sent), 64'(es));
  endtask

  task automatic drive(input logic st, input logic ab, input logic sl,
                       input logic [31:0] si, input logic [15:0] cnt, input logic rdy);
    bus.start = st; bus.abort = ab; bus.seed_load = sl;
    bus.seed_in = si; bus.pattern_count = cnt; bus.pattern_ready = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //          st ab sl seed          cnt rdy  v  pattern       b  d  sent
    vecs[0]  = mk(0, 0, 1, 32'h1,        0, 0,   0, 32'h1,        0, 0, 0);
    vecs[1]  = mk(1, 0, 0, 32'h0,        3, 1,   1, 32'h1,        1, 0, 0);
    vecs[2]  = mk(0, 0, 0, 32'h0,        0, 1,   1, 32'h2,        1, 0, 1);
    vecs[3]  = mk(0, 0, 0, 32'h0,        0, 1,   1, 32'h4,        1, 0, 2);
    vecs[4]  = mk(0, 0, 0, 32'h0,        0, 1,   0, 32'h8,        0, 1, 3);
    vecs[5]  = mk(0, 0, 0, 32'h0,        0, 1,   0, 32'h8,        0, 0, 3);
    vecs[6]  = mk(0, 0, 1, 32'h80000000, 0, 0,   0, 32'h80000000, 0, 0, 3);
    vecs[7]  = mk(1, 0, 0, 32'h0,        1, 1,   1, 32'h80000000, 1, 0, 0);
    vecs[8]  = mk(0, 0, 0, 32'h0,        0, 1,   0, 32'h80200003, 0, 1, 1);
    vecs[9]  = mk(0, 0, 0, 32'h0,        0, 0,   0, 32'h80200003, 0, 0, 1);
    vecs[10] = mk(1, 0, 0, 32'h0,        0, 0,   0, 32'h80200003, 0, 1, 0);
    vecs[11] = mk(1, 0, 0, 32'h0,        5, 0,   0, 32'h80200003, 0, 0, 0);
    vecs[12] = mk(0, 0, 1, 32'h0,        0, 0,   0, 32'hACE1ACE1, 0, 0, 0);
    vecs[13] = mk(1, 0, 1, 32'h3,        2, 0,   1, 32'h3,        1, 0, 0);
    vecs[14] = mk(0, 0, 1, 32'h55,       0, 1,   1, 32'h6,        1, 0, 1);
    vecs[15] = mk(1, 0, 0, 32'h0,        0, 1,   0, 32'hC,        0, 1, 2);
    vecs[16] = mk(0, 0, 0, 32'h0,        0, 0,   0, 32'hC,        0, 0, 2);

    // Reset state
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk_outs("reset", 0, 32'hACE1ACE1, 0, 0, 0);
    rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].start, vecs[i].abort, vecs[i].seed_load, vecs[i].seed_in,
            vecs[i].count, vecs[i].ready);
      tick();
      chk_outs($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_pat,
               vecs[i].e_busy, vecs[i].e_done, vecs[i].e_sent);
    end

    // Stall: ready low after the first valid, pattern and count must hold
    drive(0, 0, 1, 32'h1, 0, 0); tick();
    chk_outs("stall.seed", 0, 32'h1, 0, 0, 2);
    drive(1, 0, 0, 0, 4, 0); tick();
    chk_outs("stall.first", 1, 32'h1, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_outs($sformatf("stall.hold%0d", i), 1, 32'h1, 1, 0, 0);
    end
    drive(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_outs($sformatf("stall.hs%0d", i), (i < 3), 32'h1 << (i + 1), (i < 3),
               (i == 3), 16'(i + 1));
    end
    drive(0, 0, 0, 0, 0, 0); tick();
    chk_outs("stall.idle", 0, 32'h10, 0, 0, 4);

    // Abort after 2 of 10, then resume from the third LFSR state
    drive(0, 0, 1, 32'h1, 0, 0); tick();
    drive(1, 0, 0, 0, 10, 1); tick();
    chk_outs("abort.first", 1, 32'h1, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 1); tick();
    chk_outs("abort.hs1", 1, 32'h2, 1, 0, 1);
    tick();
    chk_outs("abort.hs2", 1, 32'h4, 1, 0, 2);
    drive(0, 1, 0, 0, 0, 0); tick();
    chk_outs("abort.idle", 0, 32'h4, 0, 0, 2);
    drive(0, 0, 0, 0, 0, 0); tick();
    chk_outs("abort.nodone", 0, 32'h4, 0, 0, 2);
    drive(1, 0, 0, 0, 2, 0); tick();
    chk_outs("abort.resume", 1, 32'h4, 1, 0, 0);
    drive(0, 1, 0, 0, 0, 1); tick();
    chk_outs("abort.withhs", 0, 32'h8, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0); tick();
    chk_outs("abort.withhs.nodone", 0, 32'h8, 0, 0, 1);

    // Asynchronous reset in the middle of a run
    drive(1, 0, 0, 0, 5, 0); tick();
    chk_outs("rst.run", 1, 32'h8, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 1); tick();
    chk_outs("rst.hs", 1, 32'h10, 1, 0, 1);
    #2;
    rst = 1'b1;
    #1;
    chk_outs("rst.async", 0, 32'hACE1ACE1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    tick();
    chk_outs("rst.idle", 0, 32'hACE1ACE1, 0, 0, 0);
    drive(1, 0, 0, 0, 1, 1); tick();
    chk_outs("rst.rerun", 1, 32'hACE1ACE1, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 1); tick();
    chk_outs("rst.step", 0, 32'hD9E359C1, 0, 1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lfsr_pattern_gen.md
LFSR_PATTERN_GEN -- requirements
Module: lfsr_pattern_gen

Interface
REQ-001: Parameter WIDTH, default 32, SHALL set the pattern and LFSR width in bits (legal range 8..64).
REQ-002: Parameter POLY, default 32'h8020_0003, SHALL be the Galois feedback mask (x^32+x^22+x^2+x+1).
REQ-003: Parameter DEF_SEED, default 32'hACE1_ACE1, SHALL be the reset and zero-substitution seed.
REQ-004: Parameter CNT_W, default 16, SHALL set the width of the pattern counters.
REQ-005: clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006: rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-007: start  input  1  SHALL request a test run; sampled only in IDLE.
REQ-008: abort  input  1  SHALL terminate an active run.
REQ-009: seed_load  input  1  SHALL request a seed_in capture into the LFSR.
REQ-010: seed_in  input  WIDTH  SHALL be the seed value.
REQ-011: pattern_count  input  CNT_W  SHALL be the number of patterns to issue; sampled at start.
REQ-012: pattern_ready  input  1  SHALL be asserted by the DUT/compactor side when it accepts a pattern.
REQ-013: pattern_valid  output  1  SHALL flag pattern_out as a live stimulus.
REQ-014: pattern_out  output  WIDTH  SHALL be the current LFSR state, driven straight from the register.
REQ-015: busy  output  1  SHALL be high while in RUN.
REQ-016: done  output  1  SHALL be a one-cycle pulse on normal run completion.
REQ-017: patterns_sent  output  CNT_W  SHALL count accepted patterns in the current or last run.

Function
REQ-018: The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-019: LFSR step SHALL be next = {lfsr[WIDTH-2:0],1'b0} ^ (lfsr[WIDTH-1] ? POLY : 0).
REQ-020: A handshake SHALL be the pattern_valid & pattern_ready condition in one cycle; the LFSR SHALL advance one step only on a handshake.
REQ-021: With pattern_valid high and pattern_ready low, pattern_out SHALL hold stable.
REQ-022: seed_load in IDLE or DONE SHALL load seed_in; a zero seed_in SHALL load DEF_SEED instead (lock-up avoidance).
REQ-023: seed_load in RUN SHALL be ignored.
REQ-024: IDLE with start=1 and pattern_count!=0 SHALL transition to RUN, clear patterns_sent and latch pattern_count.
REQ-025: IDLE with start=1 and pattern_count==0 SHALL transition to DONE without asserting pattern_valid.
REQ-026: start and seed_load asserted in the same IDLE cycle SHALL load the seed, and the first pattern SHALL equal the new seed.
REQ-027: pattern_valid SHALL be 1 in every RUN cycle, first asserted the cycle after start (latency 1), and 0 in IDLE and DONE.
REQ-028: Each handshake SHALL increment patterns_sent by 1.
REQ-029: The handshake that makes patterns_sent equal the latched count SHALL move the FSM to DONE.
REQ-030: DONE SHALL last exactly one cycle, with done=1, then return to IDLE.
REQ-031: abort in RUN SHALL return the FSM to IDLE next cycle with no done pulse, while holding the LFSR and patterns_sent at their current values.
REQ-032: abort and a final handshake in the same cycle SHALL take the abort path; the handshake still counts and advances the LFSR.
REQ-033: start outside IDLE SHALL be ignored.
REQ-034: The LFSR state SHALL persist across runs; a new run SHALL continue from the last state unless reseeded.

Reset
REQ-035: On rst=1, asynchronously and at any time including mid-run, the FSM SHALL enter IDLE with LFSR=DEF_SEED, patterns_sent=0, and pattern_valid, busy and done all 0.
REQ-036: Following rst deassertion, the first active edge SHALL behave as IDLE.

Verification
REQ-037: seed_load seed_in=0x00000001, then start with count=3 and ready held 1 -> pattern_out 0x1, 0x2, 0x4 on consecutive cycles; done pulses the following cycle; patterns_sent=3.
REQ-038: seed 0x80000000, count=1 -> pattern 0x80000000 accepted; LFSR afterwards reads 0x80200003.
REQ-039: count=4 with ready low for 2 cycles after the first valid -> pattern_out holds the value and patterns_sent holds at 0 during the stall; 4 handshakes in total; done after the 4th.
REQ-040: start with count=0 -> DONE the next cycle with done=1; pattern_valid never asserts.
REQ-041: abort after 2 of 10 handshakes -> IDLE with done=0 and patterns_sent=2; a new start resumes from the 3rd LFSR state.
REQ-042: rst pulse mid-RUN, and seed_load with seed_in=0 -> all outputs reset and LFSR=0xACE1ACE1 in both cases.
